mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 106 ++++++++++
 tb/tb_mem_access_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Single-port RAM access sequencer: SETUP -> STROBE -> HOLD (-> WAIT) -> DONE with registered outputs.
// Optional wait states after HOLD are compiled in with the MEM_WAIT_STATES_EN macro.
module mem_access_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_SPACE  = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [ADDR_SPACE-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_SPACE-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_datain,
  output logic                  ram_read,
  output logic                  ram_write,
  output logic                  ram_enable,
  input  logic [DATA_WIDTH-1:0] ram_dataout
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_WAIT, S_DONE
  } state_t;

  state_t state_q, state_d;
  logic   op_wr_q, op_wr_d;
  logic   accept, active_d;

  // Simultaneous read+write is ambiguous and is dropped outright.
  assign accept  = (state_q == S_IDLE) && (req_read ^ req_write);
  assign op_wr_d = accept ? req_write : op_wr_q;

`ifdef MEM_WAIT_STATES_EN
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  logic [CW-1:0] wait_cnt;
  logic          wait_last;

  assign wait_last = (wait_cnt == CW'(WAIT_CYCLES - 1));

  always_ff @(posedge clock or negedge clear) begin
    if (!clear)                 wait_cnt <= '0;
    else if (state_q != S_WAIT) wait_cnt <= '0;
    else                        wait_cnt <= wait_cnt + 1'b1;
  end
`else
  logic cfg_unused;
  assign cfg_unused = (WAIT_CYCLES != 0);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_SETUP;
      S_SETUP:  state_d = S_STROBE;
      S_STROBE: state_d = S_HOLD;
`ifdef MEM_WAIT_STATES_EN
      S_HOLD:   state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
      S_WAIT:   if (wait_last) state_d = S_DONE;
`else
      S_HOLD:   state_d = S_DONE;
      S_WAIT:   state_d = S_DONE;
`endif
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign active_d = (state_d == S_SETUP) || (state_d == S_STROBE) ||
                    (state_d == S_HOLD)  || (state_d == S_WAIT);

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q    <= S_IDLE;
      op_wr_q    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rdata      <= '0;
      ram_addr   <= '0;
      ram_datain <= '0;
      ram_read   <= 1'b0;
      ram_write  <= 1'b0;
      ram_enable <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_wr_q    <= op_wr_d;
      busy       <= (state_d != S_IDLE);
      done       <= (state_d == S_DONE);
      ram_enable <= (state_d == S_STROBE);
      ram_read   <= active_d && !op_wr_d;
      ram_write  <= active_d && op_wr_d;
      if (accept) begin
        ram_addr   <= addr;
        ram_datain <= wdata;
      end
      // RAM data is valid from the cycle after the strobe until the access ends.
      if ((state_q != S_IDLE) && (state_q != S_DONE) && (state_d == S_DONE) && !op_wr_q)
        rdata <= ram_dataout;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench: transaction-level model checked every cycle, plus directed literal checks.
module tb_mem_access_ctrl;
  localparam int DW = 32;
  localparam int AW = 9;
  localparam int WC = 2;
`ifdef MEM_WAIT_STATES_EN
  localparam int LAT = 4 + WC;
`else
  localparam int LAT = 4;
`endif

  logic          clock = 1'b0;
  logic          clear = 1'b0;
  logic          req_read = 1'b0, req_write = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic          busy, done, ram_read, ram_write, ram_enable;
  logic [DW-1:0] rdata, ram_datain;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dataout = '0;

  mem_access_ctrl #(.DATA_WIDTH(DW), .ADDR_SPACE(AW), .WAIT_CYCLES(WC)) dut (
    .clock(clock), .clear(clear), .req_read(req_read), .req_write(req_write),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .ram_addr(ram_addr), .ram_datain(ram_datain), .ram_read(ram_read),
    .ram_write(ram_write), .ram_enable(ram_enable), .ram_dataout(ram_dataout)
  );

  always #5 clock = ~clock;

  // Synchronous RAM environment.
  logic [DW-1:0] ram [512];
  always @(posedge clock) begin
    if (ram_enable) begin
      if (ram_write) ram[ram_addr] <= ram_datain;
      if (ram_read)  ram_dataout   <= ram[ram_addr];
    end
  end

  function automatic logic [DW-1:0] init_word(input int a);
    return 32'hA5A5_0000 | DW'(a);
  endfunction

  int n_chk = 0, n_fail = 0;
  bit cmp_on = 1'b0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: t counts cycles since acceptance (0 = no transaction).
  int            t = 0;
  bit            m_wr = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rdata = '0;
  logic [DW-1:0] sh [512];

  always @(posedge clock or negedge clear) begin
    if (!clear) begin
      t = 0;
      m_rdata = '0;
    end else if (t == 0) begin
      if (req_read ^ req_write) begin
        t = 1; m_wr = req_write; m_addr = addr; m_wdata = wdata;
      end
    end else if (t == LAT) begin
      t = 0;
    end else begin
      t++;
      if (t == LAT) begin
        if (m_wr) sh[m_addr] = m_wdata;
        else      m_rdata = sh[m_addr];
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_on) begin
      check("busy", busy, t != 0);
      check("done", done, t == LAT);
      check("ram_enable", ram_enable, t == 2);
      check("ram_read", ram_read, (t > 0) && (t < LAT) && !m_wr);
      check("ram_write", ram_write, (t > 0) && (t < LAT) && m_wr);
      check("rdata", rdata, m_rdata);
      check("rw_excl", ram_read & ram_write, 1'b0);
      if (t > 0 && t < LAT) begin
        check("ram_addr", ram_addr, m_addr);
        check("ram_datain", ram_datain, m_wdata);
      end
    end
  end

  task automatic issue(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clock); #2;
    req_read = rd; req_write = wr; addr = a; wdata = d;
    @(posedge clock); #2;
    req_read = 1'b0; req_write = 1'b0;
  endtask

  task automatic observe(input int n, input int pulse_k, input logic [AW-1:0] paddr,
                         output int done_k, output int done_n, output int en_n, output int busy_n,
                         output logic [DW-1:0] rd_at_done, output logic [AW+DW+1:0] en_snap);
    done_k = 0; done_n = 0; en_n = 0; busy_n = 0; rd_at_done = '0; en_snap = '0;
    for (int k = 1; k <= n; k++) begin
      if (k > 1) begin
        @(posedge clock); #2;
        req_read = (k == pulse_k);
        if (k == pulse_k) addr = paddr;
      end
      @(negedge clock);
      if (busy) busy_n++;
      if (ram_enable) begin
        en_n++;
        en_snap = {ram_read, ram_write, ram_addr, ram_datain};
      end
      if (done) begin
        done_n++;
        if (done_k == 0) begin done_k = k; rd_at_done = rdata; end
      end
    end
  endtask

  int            dk, dn, en, bn;
  logic [DW-1:0] rd;
  logic [AW+DW+1:0] snap;

  initial begin
    for (int i = 0; i < 512; i++) begin
      ram[i] = init_word(i);
      sh[i]  = init_word(i);
    end
    #1;
    check("reset_outs", {busy, done, rdata, ram_addr, ram_datain, ram_read, ram_write, ram_enable}, '0);
    cmp_on = 1'b1;
    repeat (3) @(posedge clock);
    #2 clear = 1'b1;

    // Write 0xEA to 0x048.
    issue(1'b0, 1'b1, 9'h048, 32'h0000_00EA);
    observe(LAT + 2, 0, '0, dk, dn, en, bn, rd, snap);
    check("wr_done_lat", dk, LAT);
    check("wr_done_cnt", dn, 1);
    check("wr_en_cnt", en, 1);
    check("wr_en_snap", snap, {1'b0, 1'b1, 9'h048, 32'h0000_00EA});
    check("wr_busy_cycles", bn, LAT);

    // Read it back.
    issue(1'b1, 1'b0, 9'h048, '0);
    observe(LAT + 2, 0, '0, dk, dn, en, bn, rd, snap);
    check("rd_done_lat", dk, LAT);
    check("rd_data", rd, 32'h0000_00EA);
    check("rd_busy_cycles", bn, LAT);
    check("rd_en_cnt", en, 1);

    // Conflicting request is ignored.
    issue(1'b1, 1'b1, 9'h005, 32'h77);
    observe(6, 0, '0, dk, dn, en, bn, rd, snap);
    check("cf_busy", bn, 0);
    check("cf_en", en, 0);
    check("cf_done", dn, 0);
    check("cf_rdata", rdata, 32'h0000_00EA);

    // Request pulsed during STROBE is dropped.
    issue(1'b1, 1'b0, 9'h048, '0);
    observe(LAT + 5, 2, 9'h005, dk, dn, en, bn, rd, snap);
    check("drop_done_cnt", dn, 1);
    check("drop_en_cnt", en, 1);
    check("drop_rdata", rd, 32'h0000_00EA);

    // Abort during STROBE.
    issue(1'b1, 1'b0, 9'h048, '0);
    @(negedge clock);
    @(posedge clock); #2;
    clear = 1'b0;
    #1;
    check("abort_outs", {busy, done, rdata, ram_addr, ram_datain, ram_read, ram_write, ram_enable}, '0);
    observe(3, 0, '0, dk, dn, en, bn, rd, snap);
    check("abort_done", dn, 0);
    check("abort_en", en, 0);
    @(posedge clock); #2;
    clear = 1'b1;

    issue(1'b1, 1'b0, 9'h075, '0);
    observe(LAT + 2, 0, '0, dk, dn, en, bn, rd, snap);
    check("post_abort_lat", dk, LAT);
    check("post_abort_data", rd, 32'hA5A5_0075);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      int m;
      @(posedge clock); #2;
      m = int'($urandom_range(0, 9));
      req_read  = (m == 4) || (m == 5) || (m == 8) || (m == 9);
      req_write = (m == 6) || (m == 7) || (m == 8);
      addr      = AW'($urandom_range(0, 15));
      wdata     = $urandom;
    end
    @(posedge clock); #2;
    req_read = 1'b0; req_write = 1'b0;
    repeat (LAT + 3) @(posedge clock);
    @(negedge clock);
    cmp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
